// File: rtl/alu_arbiter_pkg.sv
// Shared opcode and FSM encodings for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [1:0] OP_CONCAT = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_SHIFT  = 2'b10;
  localparam logic [1:0] OP_MULT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
  } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU: concat, add, bounded left shift, multiply; 8-bit result.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [1:0] i_s,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = 8'h00;
    case (i_s)
      OP_CONCAT: o_y = {i_a, i_b};
      OP_ADD:    o_y = {3'b000, ({1'b0, i_a} + {1'b0, i_b})};
      // Shift counts past 7 would push every bit out of the 8-bit result.
      OP_SHIFT:  o_y = (i_b > 4'd7) ? 8'h00 : ({4'b0000, i_a} << i_b);
      OP_MULT:   o_y = {4'b0000, i_a} * {4'b0000, i_b};
      default:   o_y = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// IDLE accepts, EXEC computes, RESP holds the registered result until consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_A,
  input  logic [3:0]         req0_B,
  input  logic [1:0]         req0_S,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_A,
  input  logic [3:0]         req1_B,
  input  logic [1:0]         req1_S,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [7:0]         resp_Y,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  state_e               r_state, w_state_nxt;
  op_t                  r_op;
  op_t                  w_req_op;
  logic                 r_cur_id;
  logic                 r_last_grant;
  logic [7:0]           r_resp_y;
  logic                 r_resp_id;
  logic [COUNT_W-1:0]   r_op_count;
  logic                 w_gnt;
  logic                 w_accept;
  logic [7:0]           w_alu_y;

  // On a tie the requester not served last wins; otherwise the lone valid one.
  assign w_gnt    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_req_op = w_gnt ? op_t'{req1_A, req1_B, req1_S}
                          : op_t'{req0_A, req0_B, req0_S};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((req0_valid || req1_valid) && !reset) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_gnt;
          req1_ready  = w_gnt;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= '0;
      r_cur_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_resp_y     <= 8'h00;
      r_resp_id    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= w_req_op;
        r_cur_id     <= w_gnt;
        r_last_grant <= w_gnt;
      end
      if (r_state == ST_EXEC) begin
        r_resp_y  <= w_alu_y;
        r_resp_id <= r_cur_id;
      end
      if (r_state == ST_RESP && resp_ready)
        r_op_count <= r_op_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  alu u_alu (
    .i_a (r_op.a),
    .i_b (r_op.b),
    .i_s (r_op.s),
    .o_y (w_alu_y)
  );

  assign resp_valid = (r_state == ST_RESP);
  assign busy       = (r_state != ST_IDLE);
  assign resp_Y     = r_resp_y;
  assign resp_id    = r_resp_id;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: an 8-bit-counter and a 2-bit-counter arbiter driven in parallel.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, resp_ready;
  logic [3:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0] req0_S, req1_S;
  logic       req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic [7:0] resp_Y, op_count;
  logic       r2_req0_ready, r2_req1_ready, r2_resp_valid, r2_resp_id, r2_busy;
  logic [7:0] r2_resp_Y;
  logic [1:0] op_count2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.COUNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_S(req0_S),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_S(req1_S),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_Y(resp_Y), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(r2_req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_S(req0_S),
    .req1_valid(req1_valid), .req1_ready(r2_req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_S(req1_S),
    .resp_valid(r2_resp_valid), .resp_ready(resp_ready), .resp_id(r2_resp_id),
    .resp_Y(r2_resp_Y), .busy(r2_busy), .op_count(op_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with requests already driven and resp_ready high.
  task automatic run_op(input logic eid, input logic [7:0] ey, input bit drop, input string tag);
    chk({tag, " rdy0"}, {31'b0, req0_ready}, {31'b0, eid == 1'b0});
    chk({tag, " rdy1"}, {31'b0, req1_ready}, {31'b0, eid == 1'b1});
    @(posedge clk); #1;
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    chk({tag, " exec busy"}, {31'b0, busy}, 32'd1);
    chk({tag, " exec vld"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, " exec rdy"}, {30'b0, req0_ready, req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " resp vld"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, " resp Y"}, {24'b0, resp_Y}, {24'b0, ey});
    chk({tag, " resp id"}, {31'b0, resp_id}, {31'b0, eid});
    @(posedge clk); #1;
    exp_cnt++;
    chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " cnt"}, {24'b0, op_count}, exp_cnt);
    chk({tag, " cnt2"}, {30'b0, op_count2}, exp_cnt % 4);
  endtask

  initial begin
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    logic [1:0] ts [4];
    logic [7:0] ty [4];
    ta = '{4'd9, 4'd3, 4'd1, 4'd15};
    tb = '{4'd8, 4'd2, 4'd9, 4'd15};
    ts = '{2'b01, 2'b10, 2'b10, 2'b11};
    ty = '{8'h11, 8'h0C, 8'h00, 8'hE1};

    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_A = 4'd0; req0_B = 4'd0; req0_S = 2'b00;
    req1_A = 4'd0; req1_B = 4'd0; req1_S = 2'b00;
    #12;
    chk("rst rdy0", {31'b0, req0_ready}, 32'd0);
    chk("rst rdy1", {31'b0, req1_ready}, 32'd0);
    chk("rst vld", {31'b0, resp_valid}, 32'd0);
    chk("rst id", {31'b0, resp_id}, 32'd0);
    chk("rst Y", {24'b0, resp_Y}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst cnt", {24'b0, op_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle no req", {30'b0, req0_ready, req1_ready}, 32'd0);

    // Single concat op on requester 0.
    req0_A = 4'd3; req0_B = 4'd5; req0_S = 2'b00; req0_valid = 1'b1; #1;
    run_op(1'b0, 8'h35, 1'b1, "single");

    // Every opcode through requester 1.
    for (int i = 0; i < 4; i++) begin
      req1_A = ta[i]; req1_B = tb[i]; req1_S = ts[i]; req1_valid = 1'b1; #1;
      run_op(1'b1, ty[i], 1'b1, $sformatf("op%0d", i));
    end

    // Both held valid: grants alternate starting with requester 0.
    req0_A = 4'd2; req0_B = 4'd3; req0_S = 2'b01;
    req1_A = 4'd4; req1_B = 4'd5; req1_S = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    for (int i = 0; i < 4; i++)
      run_op(i[0], i[0] ? 8'h14 : 8'h05, 1'b0, $sformatf("tie%0d", i));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure with a competing request waiting.
    resp_ready = 1'b0;
    req0_A = 4'd5; req0_B = 4'd6; req0_S = 2'b11; req0_valid = 1'b1; #1;
    chk("bp accept", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_A = 4'd7; req1_B = 4'd1; req1_S = 2'b10; req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp vld", {31'b0, resp_valid}, 32'd1);
      chk("bp Y", {24'b0, resp_Y}, 32'h1E);
      chk("bp id", {31'b0, resp_id}, 32'd0);
      chk("bp busy", {31'b0, busy}, 32'd1);
      chk("bp rdy1", {31'b0, req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    chk("bp done busy", {31'b0, busy}, 32'd0);
    chk("bp done cnt", {24'b0, op_count}, exp_cnt);
    run_op(1'b1, 8'h0E, 1'b1, "after bp");

    // Reset in the middle of RESP.
    resp_ready = 1'b0;
    req1_A = 4'd1; req1_B = 4'd1; req1_S = 2'b00; req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre rst resp", {31'b0, resp_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk("rst resp vld", {31'b0, resp_valid}, 32'd0);
    chk("rst resp busy", {31'b0, busy}, 32'd0);
    chk("rst resp Y", {24'b0, resp_Y}, 32'd0);
    chk("rst resp id", {31'b0, resp_id}, 32'd0);
    chk("rst resp cnt", {24'b0, op_count}, 32'd0);
    #2 reset = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of EXEC, after a requester-0 grant.
    req0_A = 4'd4; req0_B = 4'd4; req0_S = 2'b01; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("pre rst exec", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst exec busy", {31'b0, busy}, 32'd0);
    chk("rst exec vld", {31'b0, resp_valid}, 32'd0);
    chk("rst exec cnt", {24'b0, op_count}, 32'd0);
    chk("rst exec cnt2", {30'b0, op_count2}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // First tie after reset goes to requester 0.
    req0_A = 4'd2; req0_B = 4'd3; req0_S = 2'b01;
    req1_A = 4'd4; req1_B = 4'd5; req1_S = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    run_op(1'b0, 8'h05, 1'b1, "post rst tie");

    // Three more ops: the 2-bit counter wraps to 0 after the fourth.
    req0_A = 4'd6; req0_B = 4'd2; req0_S = 2'b10; req0_valid = 1'b1; #1;
    run_op(1'b0, 8'h18, 1'b1, "wrap1");
    req0_A = 4'd7; req0_B = 4'd7; req0_S = 2'b11; req0_valid = 1'b1; #1;
    run_op(1'b0, 8'h31, 1'b1, "wrap2");
    req0_A = 4'hA; req0_B = 4'hB; req0_S = 2'b00; req0_valid = 1'b1; #1;
    run_op(1'b0, 8'hAB, 1'b1, "wrap3");
    chk("wrap cnt2", {30'b0, op_count2}, 32'd0);
    chk("wrap cnt8", {24'b0, op_count}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
